// File: rtl/axi_rt_pkg.sv
// Shared AXI RT types and helpers: AXI burst fields and the transfer byte-cost function.
package axi_rt_pkg;

    localparam int unsigned LenWidth       = 8;
    localparam int unsigned SizeWidth      = 3;
    localparam int unsigned BeatBytesWidth = 16;

    typedef logic [LenWidth-1:0]       len_t;
    typedef logic [SizeWidth-1:0]      size_t;
    typedef logic [BeatBytesWidth-1:0] bytes_t;

    // Index width for a table of num entries; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned num);
        return (num > 32'd1) ? unsigned'($clog2(num)) : 32'd1;
    endfunction

    // Bytes moved by one burst: (len+1) << size, max 256 << 7 = 32768 fits in 16 bits.
    function automatic bytes_t beat_bytes(input len_t len, input size_t size);
        return (bytes_t'(len) + bytes_t'(1)) << size;
    endfunction

endpackage

// File: rtl/axi_rt_region_regulator.sv
// One address region: period counter plus write/read remaining-budget counters.
module axi_rt_region_regulator
    import axi_rt_pkg::*;
#(
    parameter int unsigned PeriodWidth = 32,
    parameter int unsigned BudgetWidth = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   enable_i,
    input  logic                   refresh_i,
    input  logic [PeriodWidth-1:0] period_i,
    input  logic [BudgetWidth-1:0] w_budget_i,
    input  logic [BudgetWidth-1:0] r_budget_i,
    input  logic                   aw_charge_i,
    input  bytes_t                 aw_bytes_i,
    input  logic                   ar_charge_i,
    input  bytes_t                 ar_bytes_i,
    output logic [BudgetWidth-1:0] w_left_o,
    output logic [BudgetWidth-1:0] r_left_o,
    output logic                   active_o
);

    logic [PeriodWidth-1:0] cnt_q, cnt_d;
    logic [BudgetWidth-1:0] w_left_q, w_left_d;
    logic [BudgetWidth-1:0] r_left_q, r_left_d;
    logic [BudgetWidth-1:0] w_base, r_base;
    logic                   active_q, active_d;
    logic                   due;

    // Saturating subtraction of a burst cost from a budget.
    function automatic logic [BudgetWidth-1:0] charge(input logic [BudgetWidth-1:0] base,
                                                      input logic                   hit,
                                                      input bytes_t                 bytes);
        logic [BudgetWidth-1:0] cost;
        cost = BudgetWidth'(bytes);
        if (!hit) begin
            return base;
        end
        return (base > cost) ? (base - cost) : '0;
    endfunction

    always_comb begin
        cnt_d    = cnt_q;
        w_left_d = w_left_q;
        r_left_d = r_left_q;
        w_base   = w_left_q;
        r_base   = r_left_q;
        active_d = 1'b0;
        // A lowered period compares >= so it never wraps past the new end.
        due      = (cnt_q >= (period_i - PeriodWidth'(1)));
        if (!enable_i) begin
            cnt_d    = '0;
            w_left_d = '0;
            r_left_d = '0;
        end else if (period_i == '0) begin
            cnt_d    = '0;
            w_left_d = w_budget_i;
            r_left_d = r_budget_i;
        end else begin
            active_d = 1'b1;
            if (refresh_i || due) begin
                cnt_d  = '0;
                w_base = w_budget_i;
                r_base = r_budget_i;
            end else begin
                cnt_d = cnt_q + PeriodWidth'(1);
            end
            w_left_d = charge(w_base, aw_charge_i, aw_bytes_i);
            r_left_d = charge(r_base, ar_charge_i, ar_bytes_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            w_left_q <= '0;
            r_left_q <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            w_left_q <= w_left_d;
            r_left_q <= r_left_d;
            active_q <= active_d;
        end
    end

    assign w_left_o = w_left_q;
    assign r_left_o = r_left_q;
    assign active_o = active_q;

endmodule

// File: rtl/axi_rt_budget_regulator.sv
// Per-manager bandwidth regulator: charges AW/AR bursts against per-region budgets
// and requests isolation while any regulated region is exhausted.
module axi_rt_budget_regulator
    import axi_rt_pkg::*;
#(
    parameter int unsigned NumAddrRegions = 2,
    parameter int unsigned PeriodWidth    = 32,
    parameter int unsigned BudgetWidth    = 32,
    parameter int unsigned RegionIdxWidth = idx_width(NumAddrRegions)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  enable_i,
    input  logic [NumAddrRegions*PeriodWidth-1:0] period_i,
    input  logic [NumAddrRegions*BudgetWidth-1:0] w_budget_i,
    input  logic [NumAddrRegions*BudgetWidth-1:0] r_budget_i,
    input  logic                                  aw_hs_i,
    input  logic [LenWidth-1:0]                   aw_len_i,
    input  logic [SizeWidth-1:0]                  aw_size_i,
    input  logic [RegionIdxWidth-1:0]             aw_region_i,
    input  logic                                  ar_hs_i,
    input  logic [LenWidth-1:0]                   ar_len_i,
    input  logic [SizeWidth-1:0]                  ar_size_i,
    input  logic [RegionIdxWidth-1:0]             ar_region_i,
    output logic [NumAddrRegions*BudgetWidth-1:0] w_left_o,
    output logic [NumAddrRegions*BudgetWidth-1:0] r_left_o,
    output logic                                  isolate_o
);

    logic                      enable_q;
    logic                      isolate_q;
    logic                      refresh_start;
    logic [NumAddrRegions-1:0] active;
    logic [NumAddrRegions-1:0] exhausted;
    bytes_t                    aw_bytes;
    bytes_t                    ar_bytes;

    assign refresh_start = enable_i & ~enable_q;
    assign aw_bytes      = beat_bytes(len_t'(aw_len_i), size_t'(aw_size_i));
    assign ar_bytes      = beat_bytes(len_t'(ar_len_i), size_t'(ar_size_i));

    for (genvar r = 0; r < NumAddrRegions; r++) begin : gen_region
        logic [BudgetWidth-1:0] w_left;
        logic [BudgetWidth-1:0] r_left;

        // Out-of-range region indices match no instance and are ignored.
        axi_rt_region_regulator #(
            .PeriodWidth (PeriodWidth),
            .BudgetWidth (BudgetWidth)
        ) u_region (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .enable_i    (enable_i),
            .refresh_i   (refresh_start),
            .period_i    (period_i[r*PeriodWidth +: PeriodWidth]),
            .w_budget_i  (w_budget_i[r*BudgetWidth +: BudgetWidth]),
            .r_budget_i  (r_budget_i[r*BudgetWidth +: BudgetWidth]),
            .aw_charge_i (aw_hs_i && (aw_region_i == RegionIdxWidth'(r))),
            .aw_bytes_i  (aw_bytes),
            .ar_charge_i (ar_hs_i && (ar_region_i == RegionIdxWidth'(r))),
            .ar_bytes_i  (ar_bytes),
            .w_left_o    (w_left),
            .r_left_o    (r_left),
            .active_o    (active[r])
        );

        assign w_left_o[r*BudgetWidth +: BudgetWidth] = w_left;
        assign r_left_o[r*BudgetWidth +: BudgetWidth] = r_left;
        assign exhausted[r] = active[r] & ((w_left == '0) | (r_left == '0));
    end

    // Isolation follows the budget state by one cycle; disabling drops it at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            enable_q  <= 1'b0;
            isolate_q <= 1'b0;
        end else begin
            enable_q  <= enable_i;
            isolate_q <= enable_i & (|exhausted);
        end
    end

    assign isolate_o = isolate_q;

endmodule

// File: tb/tb_axi_rt_budget_regulator.sv
// Self-checking bench: directed scenarios then random traffic against a cycle-level budget model.
module tb_axi_rt_budget_regulator;

    localparam int unsigned NR = 2;
    localparam int unsigned PW = 32;
    localparam int unsigned BW = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic [PW-1:0]     per [NR];
    logic [BW-1:0]     wb  [NR];
    logic [BW-1:0]     rb  [NR];
    logic              aw_hs = 1'b0, ar_hs = 1'b0;
    logic [7:0]        aw_len = '0, ar_len = '0;
    logic [2:0]        aw_size = '0, ar_size = '0;
    logic [0:0]        aw_region = '0, ar_region = '0;
    logic [NR*PW-1:0]  period_flat;
    logic [NR*BW-1:0]  wb_flat, rb_flat, w_left, r_left;
    logic              isolate;

    int errors = 0;
    int checks = 0;

    // Reference state: remaining budgets, cycles since refresh, whether region was regulated.
    logic [BW-1:0] m_w [NR];
    logic [BW-1:0] m_r [NR];
    int unsigned   m_age [NR];
    bit            m_act [NR];
    bit            m_en_q;
    bit            m_iso;

    assign period_flat = {per[1], per[0]};
    assign wb_flat     = {wb[1], wb[0]};
    assign rb_flat     = {rb[1], rb[0]};

    always #5 clk = ~clk;

    axi_rt_budget_regulator #(
        .NumAddrRegions (NR),
        .PeriodWidth    (PW),
        .BudgetWidth    (BW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .enable_i    (en),
        .period_i    (period_flat),
        .w_budget_i  (wb_flat),
        .r_budget_i  (rb_flat),
        .aw_hs_i     (aw_hs),
        .aw_len_i    (aw_len),
        .aw_size_i   (aw_size),
        .aw_region_i (aw_region),
        .ar_hs_i     (ar_hs),
        .ar_len_i    (ar_len),
        .ar_size_i   (ar_size),
        .ar_region_i (ar_region),
        .w_left_o    (w_left),
        .r_left_o    (r_left),
        .isolate_o   (isolate)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] spend(input logic [BW-1:0] left, input int unsigned cost);
        return (longint'(left) > longint'(cost)) ? left - BW'(cost) : '0;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            m_w[r] = '0; m_r[r] = '0; m_age[r] = 0; m_act[r] = 1'b0;
        end
        m_en_q = 1'b0;
        m_iso  = 1'b0;
    endtask

    task automatic model_step();
        bit iso_n;
        bit refresh;
        iso_n = 1'b0;
        for (int r = 0; r < NR; r++)
            if (en && m_act[r] && (m_w[r] == 0 || m_r[r] == 0)) iso_n = 1'b1;
        for (int r = 0; r < NR; r++) begin
            if (!en) begin
                m_w[r] = '0; m_r[r] = '0; m_age[r] = 0; m_act[r] = 1'b0;
            end else if (per[r] == 0) begin
                m_w[r] = wb[r]; m_r[r] = rb[r]; m_age[r] = 0; m_act[r] = 1'b0;
            end else begin
                refresh = !m_en_q || (longint'(m_age[r]) + 1 >= longint'(per[r]));
                if (refresh) begin
                    m_w[r] = wb[r]; m_r[r] = rb[r]; m_age[r] = 0;
                end else begin
                    m_age[r] = m_age[r] + 1;
                end
                if (aw_hs && int'(aw_region) == r)
                    m_w[r] = spend(m_w[r], (int'(aw_len) + 1) * (2 ** int'(aw_size)));
                if (ar_hs && int'(ar_region) == r)
                    m_r[r] = spend(m_r[r], (int'(ar_len) + 1) * (2 ** int'(ar_size)));
                m_act[r] = 1'b1;
            end
        end
        m_en_q = en;
        m_iso  = iso_n;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        chk("w_left", 64'(w_left), 64'({m_w[1], m_w[0]}));
        chk("r_left", 64'(r_left), 64'({m_r[1], m_r[0]}));
        chk("isolate", 64'(isolate), 64'(m_iso));
    endtask

    task automatic idle();
        aw_hs = 1'b0;
        ar_hs = 1'b0;
    endtask

    task automatic wait_age(input int r, input int unsigned target, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (m_age[r] == target) begin
                hit = 1'b1;
                break;
            end
            step();
        end
        chk(tag, 64'(hit), 64'd1);
    endtask

    initial begin
        for (int r = 0; r < NR; r++) begin
            per[r] = '0; wb[r] = '0; rb[r] = '0;
        end
        model_reset();
        step();
        step();
        chk("reset_w_left", 64'(w_left), 64'd0);
        chk("reset_isolate", 64'(isolate), 64'd0);

        // Region 0 regulated, region 1 off with zero budget.
        rst_n = 1'b1;
        per[0] = 10; wb[0] = 64; rb[0] = 64;
        en = 1'b1;
        step();
        chk("enable_w_left0", 64'(w_left[31:0]), 64'd64);
        chk("enable_isolate", 64'(isolate), 64'd0);

        aw_hs = 1'b1; aw_len = 8'd3; aw_size = 3'd3; aw_region = 1'b0;
        step();
        chk("aw32_w_left0", 64'(w_left[31:0]), 64'd32);
        step();
        chk("aw32x2_w_left0", 64'(w_left[31:0]), 64'd0);
        idle();
        step();
        chk("exhaust_isolate", 64'(isolate), 64'd1);
        wait_age(0, 9, "wait_refresh0");
        step();
        chk("refresh_w_left0", 64'(w_left[31:0]), 64'd64);
        chk("refresh_isolate_still", 64'(isolate), 64'd1);
        step();
        chk("refresh_isolate_clear", 64'(isolate), 64'd0);

        aw_hs = 1'b1; aw_len = 8'd255; aw_size = 3'd7;
        step();
        chk("saturate_w_left0", 64'(w_left[31:0]), 64'd0);
        idle();

        wait_age(0, 9, "wait_refresh1");
        aw_hs = 1'b1; aw_len = 8'd1; aw_size = 3'd3;
        step();
        chk("charge_on_refresh", 64'(w_left[31:0]), 64'd48);
        idle();

        wb[1] = 100; rb[1] = 100;
        step();
        chk("period0_no_isolate", 64'(isolate), 64'd0);
        per[1] = 20;
        aw_hs = 1'b1; aw_len = 8'd0; aw_size = 3'd3; aw_region = 1'b1;
        ar_hs = 1'b1; ar_len = 8'd0; ar_size = 3'd3; ar_region = 1'b1;
        step();
        chk("same_cycle_w_left1", 64'(w_left[63:32]), 64'd92);
        chk("same_cycle_r_left1", 64'(r_left[63:32]), 64'd92);
        idle();

        per[1] = 100;
        wait_age(1, 50, "wait_cnt50");
        chk("mid_period_before", 64'(w_left[63:32]), 64'd92);
        per[1] = 5;
        step();
        chk("mid_period_refresh", 64'(w_left[63:32]), 64'd100);

        // Random traffic, config changes and enable toggles.
        for (int i = 0; i < 500; i++) begin
            aw_hs     = ($urandom_range(2, 0) == 0);
            aw_len    = ($urandom_range(9, 0) == 0) ? 8'($urandom) : 8'($urandom_range(15, 0));
            aw_size   = 3'($urandom_range(7, 0));
            aw_region = 1'($urandom);
            ar_hs     = ($urandom_range(2, 0) == 0);
            ar_len    = 8'($urandom_range(15, 0));
            ar_size   = 3'($urandom_range(4, 0));
            ar_region = 1'($urandom);
            if ($urandom_range(19, 0) == 0) begin
                int r;
                r = int'($urandom_range(1, 0));
                per[r] = PW'($urandom_range(12, 0));
                wb[r]  = BW'($urandom_range(400, 0));
                rb[r]  = BW'($urandom_range(400, 0));
            end
            if ($urandom_range(49, 0) == 0) en = ~en;
            step();
        end

        // Asynchronous reset mid-run.
        en = 1'b1;
        per[0] = 7; wb[0] = 200; rb[0] = 200;
        step();
        step();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_w_left", 64'(w_left), 64'd0);
        chk("async_rst_r_left", 64'(r_left), 64'd0);
        chk("async_rst_isolate", 64'(isolate), 64'd0);
        idle();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
